// File: rtl/expr_eval_seq_if.sv
// ============================================================================
// expr_eval_seq_if : command, evaluator and result signals of expr_eval_seq
// Rev 1.0
// ============================================================================
`default_nettype none

interface expr_eval_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_x;
   logic [3:0]  cmd_sel;
   logic        cmd_sweep;

   logic [7:0]  eval_x;
   logic [3:0]  eval_sel;
   logic [31:0] eval_result;

   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [3:0]  res_sel;
   logic        res_last;
   logic        res_err;

   // Sequencer view
   modport slave (
      input  cmd_valid, cmd_x, cmd_sel, cmd_sweep, eval_result, res_ready,
      output cmd_ready, eval_x, eval_sel,
      output res_valid, res_data, res_sel, res_last, res_err
   );

   // Command source / result sink / evaluator view
   modport master (
      output cmd_valid, cmd_x, cmd_sel, cmd_sweep, eval_result, res_ready,
      input  cmd_ready, eval_x, eval_sel,
      input  res_valid, res_data, res_sel, res_last, res_err
   );
endinterface

`default_nettype wire

// File: rtl/expr_eval_seq.sv
// ============================================================================
// expr_eval_seq : command sequencer driving a fixed-latency expression evaluator
// Rev 1.0
// ============================================================================
`default_nettype none

module expr_eval_seq #(
   parameter int NUM_FUNC = 9,
   parameter int EVAL_LAT = 2
) (
   input  wire logic          clk,
   input  wire logic          rst,
   expr_eval_seq_if.slave     bus,
   output logic               busy
);

   localparam int CNT_W = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
   localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(EVAL_LAT - 1);
   localparam logic [3:0]       c_LAST_SEL = 4'(NUM_FUNC - 1);
   localparam logic [4:0]       c_NUM_FUNC = 5'(NUM_FUNC);
   localparam logic [31:0]      c_QNAN     = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_OUTPUT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        eval_x_q, eval_x_d;
   logic [3:0]        eval_sel_q, eval_sel_d;
   logic              sweep_q, sweep_d;
   logic              res_valid_q, res_valid_d;
   logic [31:0]       res_data_q, res_data_d;
   logic [3:0]        res_sel_q, res_sel_d;
   logic              res_last_q, res_last_d;
   logic              res_err_q, res_err_d;

   logic              w_illegal;

   assign w_illegal = ({1'b0, bus.cmd_sel} >= c_NUM_FUNC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         eval_x_q    <= '0;
         eval_sel_q  <= '0;
         sweep_q     <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_sel_q   <= '0;
         res_last_q  <= 1'b0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         eval_x_q    <= eval_x_d;
         eval_sel_q  <= eval_sel_d;
         sweep_q     <= sweep_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_sel_q   <= res_sel_d;
         res_last_q  <= res_last_d;
         res_err_q   <= res_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      eval_x_d    = eval_x_q;
      eval_sel_d  = eval_sel_q;
      sweep_d     = sweep_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_sel_d   = res_sel_q;
      res_last_d  = res_last_q;
      res_err_d   = res_err_q;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               if (!bus.cmd_sweep && w_illegal) begin
                  // Illegal select never reaches the evaluator; answer with qNaN
                  sweep_d     = 1'b0;
                  res_valid_d = 1'b1;
                  res_data_d  = c_QNAN;
                  res_sel_d   = bus.cmd_sel;
                  res_last_d  = 1'b1;
                  res_err_d   = 1'b1;
                  state_d     = S_OUTPUT;
               end else begin
                  eval_x_d   = bus.cmd_x;
                  eval_sel_d = bus.cmd_sweep ? 4'd0 : bus.cmd_sel;
                  sweep_d    = bus.cmd_sweep;
                  cnt_d      = '0;
                  state_d    = S_WAIT;
               end
            end
         end

         S_WAIT: begin
            if (cnt_q == c_LAST_CNT) begin
               res_valid_d = 1'b1;
               res_data_d  = bus.eval_result;
               res_sel_d   = eval_sel_q;
               res_err_d   = 1'b0;
               res_last_d  = !sweep_q || (eval_sel_q == c_LAST_SEL);
               state_d     = S_OUTPUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_OUTPUT: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               if (res_last_q) begin
                  state_d = S_IDLE;
               end else begin
                  eval_sel_d = eval_sel_q + 4'd1;
                  cnt_d      = '0;
                  state_d    = S_WAIT;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // cmd_ready is held low while reset is asserted so a command cannot slip in
   assign bus.cmd_ready = (state_q == S_IDLE) && !rst;
   assign busy          = (state_q != S_IDLE);
   assign bus.eval_x    = eval_x_q;
   assign bus.eval_sel  = eval_sel_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_sel   = res_sel_q;
   assign bus.res_last  = res_last_q;
   assign bus.res_err   = res_err_q;

endmodule

`default_nettype wire
